// File: rtl/hovalaag_out_checker.sv
// hovalaag_out_checker
//   Watches the CPU output stream in the board harness. Each OUT word is checked
//   against an expected-output ROM. Each channel keeps its own word index.
//   Mismatches are counted, and the first failure is latched. done/pass go high
//   once both channels have produced their expected number of words.
//
// Ports
//   clk, reset        board clock, synchronous active-high reset
//   out_strobe        one-clk pulse per slow CPU cycle; qualifies out_valid
//   out_valid/select  CPU OUT_valid / OUT_select (0=OUT1, 1=OUT2)
//   out_data          CPU OUT word
//   exp_len1/2        expected word counts (static between resets)
//   rom_addr/rom_data expected-ROM address {chan, idx} / word (1 clk latency)
//   err_count         saturating mismatch count
//   first_err_*       channel, index and received word of the first mismatch
//   extra, overflow   sticky harness/program fault flags
//   done, pass        completion and overall verdict
module hovalaag_out_checker #(
  parameter int IDX_W = 7,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             out_strobe,
  input  logic             out_valid,
  input  logic             out_select,
  input  logic [11:0]      out_data,
  input  logic [IDX_W:0]   exp_len1,
  input  logic [IDX_W:0]   exp_len2,
  output logic [IDX_W:0]   rom_addr,
  input  logic [11:0]      rom_data,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_chan,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [11:0]      first_err_got,
  output logic             extra,
  output logic             overflow,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_CMP} state_t;

  localparam logic [IDX_W:0]   IDX_ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             pend_full_q, pend_full_d;
  logic             pend_chan_q, pend_chan_d;
  logic [11:0]      pend_data_q, pend_data_d;
  logic             work_chan_q, work_chan_d;
  logic [11:0]      work_data_q, work_data_d;
  logic [IDX_W:0]   idx1_q, idx1_d;
  logic [IDX_W:0]   idx2_q, idx2_d;
  logic [IDX_W:0]   rom_addr_q, rom_addr_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             first_chan_q, first_chan_d;
  logic [IDX_W-1:0] first_idx_q, first_idx_d;
  logic [11:0]      first_got_q, first_got_d;
  logic             extra_q, extra_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic             accept;
  logic             take;
  logic [IDX_W:0]   cur_idx;
  logic [IDX_W:0]   cur_len;

  assign accept  = out_strobe & out_valid;
  assign take    = (state_q == S_IDLE) & pend_full_q;
  assign cur_idx = work_chan_q ? idx2_q : idx1_q;
  assign cur_len = work_chan_q ? exp_len2 : exp_len1;

  always_comb begin
    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_chan_d = pend_chan_q;
    pend_data_d = pend_data_q;
    work_chan_d = work_chan_q;
    work_data_d = work_data_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    rom_addr_d  = rom_addr_q;
    err_count_d = err_count_q;
    first_chan_d = first_chan_q;
    first_idx_d = first_idx_q;
    first_got_d = first_got_q;
    extra_d     = extra_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          work_chan_d = pend_chan_q;
          work_data_d = pend_data_q;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        rom_addr_d = {work_chan_q, cur_idx[IDX_W-1:0]};
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // rom_data for the address set in FETCH is valid in CMP
        state_d = S_CMP;
      end
      S_CMP: begin
        if (cur_idx == cur_len) begin
          extra_d = 1'b1;
        end else begin
          if (rom_data != work_data_q) begin
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_ONE;
            end
            if (err_count_q == '0) begin
              first_chan_d = work_chan_q;
              first_idx_d  = cur_idx[IDX_W-1:0];
              first_got_d  = work_data_q;
            end
          end
          if (work_chan_q) begin
            idx2_d = idx2_q + IDX_ONE;
          end else begin
            idx1_d = idx1_q + IDX_ONE;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pending slot: freed by the FSM in IDLE; an accept in that same cycle
    // refills it, otherwise an accept into a full slot is dropped.
    if (take) begin
      pend_full_d = 1'b0;
    end
    if (accept) begin
      if (pend_full_q && !take) begin
        overflow_d = 1'b1;
      end else begin
        pend_full_d = 1'b1;
        pend_chan_d = out_select;
        pend_data_d = out_data;
      end
    end

    done_d = (idx1_d == exp_len1) && (idx2_d == exp_len2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pend_full_q  <= 1'b0;
      pend_chan_q  <= 1'b0;
      pend_data_q  <= '0;
      work_chan_q  <= 1'b0;
      work_data_q  <= '0;
      idx1_q       <= '0;
      idx2_q       <= '0;
      rom_addr_q   <= '0;
      err_count_q  <= '0;
      first_chan_q <= 1'b0;
      first_idx_q  <= '0;
      first_got_q  <= '0;
      extra_q      <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_full_q  <= pend_full_d;
      pend_chan_q  <= pend_chan_d;
      pend_data_q  <= pend_data_d;
      work_chan_q  <= work_chan_d;
      work_data_q  <= work_data_d;
      idx1_q       <= idx1_d;
      idx2_q       <= idx2_d;
      rom_addr_q   <= rom_addr_d;
      err_count_q  <= err_count_d;
      first_chan_q <= first_chan_d;
      first_idx_q  <= first_idx_d;
      first_got_q  <= first_got_d;
      extra_q      <= extra_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign err_count      = err_count_q;
  assign first_err_chan = first_chan_q;
  assign first_err_idx  = first_idx_q;
  assign first_err_got  = first_got_q;
  assign extra          = extra_q;
  assign overflow       = overflow_q;
  assign done           = done_q;
  assign pass           = done_q & (err_count_q == '0) & ~extra_q & ~overflow_q;

endmodule

// File: tb/tb_hovalaag_out_checker.sv
// Directed testbench for hovalaag_out_checker with a synchronous expected ROM.
module tb_hovalaag_out_checker;
  localparam int IDX_W = 7;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             out_strobe = 1'b0;
  logic             out_valid = 1'b0;
  logic             out_select = 1'b0;
  logic [11:0]      out_data = '0;
  logic [IDX_W:0]   exp_len1 = 8'd3;
  logic [IDX_W:0]   exp_len2 = 8'd2;
  logic [IDX_W:0]   rom_addr;
  logic [11:0]      rom_data;
  logic [ERR_W-1:0] err_count;
  logic             first_err_chan;
  logic [IDX_W-1:0] first_err_idx;
  logic [11:0]      first_err_got;
  logic             extra, overflow, done, pass;

  logic [11:0] rom [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  hovalaag_out_checker #(.IDX_W(IDX_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .out_strobe(out_strobe), .out_valid(out_valid),
    .out_select(out_select), .out_data(out_data), .exp_len1(exp_len1),
    .exp_len2(exp_len2), .rom_addr(rom_addr), .rom_data(rom_data),
    .err_count(err_count), .first_err_chan(first_err_chan),
    .first_err_idx(first_err_idx), .first_err_got(first_err_got),
    .extra(extra), .overflow(overflow), .done(done), .pass(pass)
  );

  // Holds reset for two edges, leaving time at #1 after an edge.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One strobed word, then idle so that words are 'gap' clk apart.
  task automatic send(input logic sel, input logic [11:0] d, input int gap);
    out_strobe = 1'b1; out_valid = 1'b1; out_select = sel; out_data = d;
    @(posedge clk); #1;
    out_strobe = 1'b0; out_valid = 1'b0;
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic send_matching_stream();
    send(1'b0, 12'h001, 8);
    send(1'b1, 12'hFFF, 8);
    send(1'b0, 12'h002, 8);
    send(1'b1, 12'h800, 8);
    send(1'b0, 12'h003, 8);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rom_addr, err_count, first_err_chan, first_err_idx, first_err_got,
         extra, overflow, done, pass} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h err=%h fc=%b fi=%h fg=%h x=%b o=%b d=%b p=%b exp all 0",
               rom_addr, err_count, first_err_chan, first_err_idx, first_err_got,
               extra, overflow, done, pass);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done_after got %b exp 0", done); end
    $display("test_reset done");
  endtask

  task automatic test_match();
    do_reset();
    send(1'b0, 12'h001, 8);
    send(1'b1, 12'hFFF, 8);
    send(1'b0, 12'h002, 8);
    send(1'b1, 12'h800, 8);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL match_not_done got %b exp 0", done); end
    send(1'b0, 12'h003, 8);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL match_done got %b exp 1", done); end
    checks++;
    if (pass !== 1'b1) begin errors++; $display("FAIL match_pass got %b exp 1", pass); end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL match_err got %0d exp 0", err_count); end
    checks++;
    if (rom_addr !== 8'h02) begin errors++; $display("FAIL match_rom_addr got %h exp 02", rom_addr); end
    $display("test_match done");
  endtask

  task automatic test_mismatch();
    do_reset();
    send(1'b0, 12'h001, 8);
    send(1'b0, 12'h0A5, 8);
    checks++;
    if (err_count !== 8'd1) begin errors++; $display("FAIL mm1_err got %0d exp 1", err_count); end
    checks++;
    if (first_err_chan !== 1'b0) begin errors++; $display("FAIL mm1_chan got %b exp 0", first_err_chan); end
    checks++;
    if (first_err_idx !== 7'd1) begin errors++; $display("FAIL mm1_idx got %0d exp 1", first_err_idx); end
    checks++;
    if (first_err_got !== 12'h0A5) begin errors++; $display("FAIL mm1_got got %h exp 0a5", first_err_got); end
    send(1'b1, 12'h123, 8);
    checks++;
    if (err_count !== 8'd2) begin errors++; $display("FAIL mm2_err got %0d exp 2", err_count); end
    checks++;
    if ({first_err_chan, first_err_idx, first_err_got} !== {1'b0, 7'd1, 12'h0A5}) begin
      errors++;
      $display("FAIL mm2_first got %b/%0d/%h exp 0/1/0a5", first_err_chan, first_err_idx, first_err_got);
    end
    send(1'b0, 12'h003, 8);
    send(1'b1, 12'h800, 8);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL mm_done got %b exp 1", done); end
    checks++;
    if (pass !== 1'b0) begin errors++; $display("FAIL mm_pass got %b exp 0", pass); end
    $display("test_mismatch done");
  endtask

  task automatic test_held_level();
    do_reset();
    out_valid = 1'b1; out_select = 1'b0; out_data = 12'h001;
    repeat (10) @(posedge clk);
    #1; out_strobe = 1'b1;
    @(posedge clk); #1; out_strobe = 1'b0;
    repeat (9) @(posedge clk);
    #1; out_valid = 1'b0;
    // A second count of the held word would compare against rom[1]=0x002.
    send(1'b0, 12'h002, 8);
    checks++;
    if (rom_addr !== 8'h01) begin errors++; $display("FAIL held_idx got addr %h exp 01", rom_addr); end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL held_err got %0d exp 0", err_count); end
    $display("test_held_level done");
  endtask

  task automatic test_extra();
    do_reset();
    send_matching_stream();
    send(1'b0, 12'h007, 8);
    checks++;
    if (extra !== 1'b1) begin errors++; $display("FAIL extra_flag got %b exp 1", extra); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL extra_done got %b exp 1", done); end
    checks++;
    if (pass !== 1'b0) begin errors++; $display("FAIL extra_pass got %b exp 0", pass); end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL extra_err got %0d exp 0", err_count); end
    send(1'b0, 12'h008, 8);
    checks++;
    if (rom_addr !== 8'h03) begin errors++; $display("FAIL extra_idx got addr %h exp 03", rom_addr); end
    $display("test_extra done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_strobe = 1'b1; out_valid = 1'b1; out_select = 1'b0; out_data = 12'h001;
    @(posedge clk); #1; out_data = 12'h002;
    @(posedge clk); #1; out_select = 1'b1; out_data = 12'hFFF;
    @(posedge clk); #1; out_strobe = 1'b0; out_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow got %b exp 1", overflow); end
    checks++;
    if (rom_addr !== 8'h01) begin errors++; $display("FAIL b2b_addr got %h exp 01", rom_addr); end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL b2b_err got %0d exp 0", err_count); end
    do_reset();
    send(1'b0, 12'h001, 4);
    send(1'b0, 12'h002, 4);
    send(1'b0, 12'h003, 4);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL gap4_overflow got %b exp 0", overflow); end
    checks++;
    if (rom_addr !== 8'h02) begin errors++; $display("FAIL gap4_addr got %h exp 02", rom_addr); end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL gap4_err got %0d exp 0", err_count); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    out_strobe = 1'b1; out_valid = 1'b1; out_select = 1'b0; out_data = 12'h0F0;
    @(posedge clk); #1; out_strobe = 1'b0; out_valid = 1'b0;  // accepted
    @(posedge clk);                                            // -> FETCH
    @(posedge clk); #1;                                        // -> WAIT
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rom_addr, err_count, first_err_got, extra, overflow, done, pass} !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs got addr=%h err=%0d fg=%h x=%b o=%b d=%b p=%b exp all 0",
               rom_addr, err_count, first_err_got, extra, overflow, done, pass);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL rst_wait_err got %0d exp 0", err_count); end
    send(1'b0, 12'h001, 8);
    checks++;
    if (rom_addr !== 8'h00) begin errors++; $display("FAIL rst_wait_idx got addr %h exp 00", rom_addr); end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL rst_wait_err2 got %0d exp 0", err_count); end
    $display("test_reset_in_wait done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    rom[0]   = 12'h001;
    rom[1]   = 12'h002;
    rom[2]   = 12'h003;
    rom[128] = 12'hFFF;
    rom[129] = 12'h800;
    test_reset();
    test_match();
    test_mismatch();
    test_held_level();
    test_extra();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
